seq_multiplier_param: RTL

Parametrised radix-2 shift-add sequential multiplier. It is the next generation of the team's 4-bit sequential multiplier, generalised to WIDTH-bit operands, with a per-transaction signed/unsigned mode and valid/ready handshakes on both sides. It processes one multiplier bit per cycle and holds its result until the consumer accepts it. It sits between the pin-mux input capture and the output register bank of the tile.

---
 rtl/seq_mul_pkg.sv | 26 ++
 rtl/seq_mul_datapath.sv | 66 ++++++
 rtl/seq_multiplier_param.sv | 87 ++++++++
 3 files changed

// File: rtl/seq_mul_pkg.sv
// Shared state type and arithmetic helpers for the seq_multiplier_param slice.
package seq_mul_pkg;

    localparam int unsigned MAX_W  = 16;
    localparam int unsigned MAX_PW = 2 * MAX_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    // Caller zero-extends the operand and truncates the result back to its own width.
    function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] v, input logic is_neg);
        return is_neg ? (~v + MAX_W'(1)) : v;
    endfunction

    function automatic logic [MAX_PW-1:0] negate(input logic [MAX_PW-1:0] v);
        return ~v + MAX_PW'(1);
    endfunction

endpackage

// File: rtl/seq_mul_datapath.sv
// Operand magnitudes, shift-add accumulator and final sign fix-up.
// SEQ_MULTIPLIER_EARLY_TERM_EN: complete as soon as the remaining multiplier bits are zero.
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               last,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_mag_next;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               a_neg;
    logic               b_neg;

    assign a_neg      = in_signed & in_a[WIDTH-1];
    assign b_neg      = in_signed & in_b[WIDTH-1];
    assign b_mag_next = b_mag >> 1;
    assign acc_next   = acc + (b_mag[0] ? ({{WIDTH{1'b0}}, a_mag} << cnt) : '0);

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    assign last = (cnt == CNT_W'(WIDTH - 1)) || (b_mag_next == '0);
`else
    assign last = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (load) begin
            a_mag <= WIDTH'(abs_mag(MAX_W'(in_a), a_neg));
            b_mag <= WIDTH'(abs_mag(MAX_W'(in_b), b_neg));
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_next;
            b_mag <= b_mag_next;
            cnt   <= cnt + CNT_W'(1);
            if (finish) begin
                product <= neg ? (2*WIDTH)'(negate(MAX_PW'(acc_next))) : acc_next;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier_param.sv
// Radix-2 shift-add sequential multiplier with valid/ready on both sides.
// SEQ_MULTIPLIER_EARLY_TERM_EN (see seq_mul_datapath) enables data-dependent latency.
module seq_multiplier_param
    import seq_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t state;
    state_t state_next;
    logic   load;
    logic   step;
    logic   finish;
    logic   last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    seq_mul_datapath #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .in_signed(in_signed),
        .in_a     (in_a),
        .in_b     (in_b),
        .last     (last),
        .product  (out_product)
    );

endmodule
